// File: rtl/ca_prng_gen.sv
// rtl/ca_prng_gen.sv - hybrid rule-90/150 cellular-automaton PRNG with valid/ready output
//
// Purpose:
//   Null-boundary hybrid CA generator. One CA advance per accepted sample,
//   runtime reseed, sample limit with DONE state, sticky zero-seed flag.
//   Optional macro CA_PRNG_LEAP_EN adds parameter LEAP (1..8): each advance
//   applies the CA step LEAP times.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   enable      allows sample generation
//   load        one-cycle seed load strobe
//   load_seed   seed value sampled when load=1 (zero -> SEED, flags seed_err)
//   out_data    current sample
//   out_valid   out_data valid
//   out_ready   consumer accepts sample
//   done        MAX_COUNT samples accepted
//   seed_err    sticky: an all-zero seed was loaded
//   sample_cnt  samples accepted since reset/load (saturates)
module ca_prng_gen #(
    parameter int               WIDTH     = 24,
    parameter logic [WIDTH-1:0] RULE_MASK = 24'hD55555,
    parameter logic [WIDTH-1:0] SEED      = 24'h99B3AB,
    parameter int               MAX_COUNT = 1048576,
    parameter int               COUNT_W   = 21
`ifdef CA_PRNG_LEAP_EN
    ,
    parameter int               LEAP      = 1
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_seed,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               done,
    output logic               seed_err,
    output logic [COUNT_W-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(MAX_COUNT);

    fsm_t               fsm_q, fsm_d;
    logic [WIDTH-1:0]   state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   adv;
    logic [COUNT_W-1:0] cnt_inc;

    // One CA step; the zero padding on both ends is the null boundary.
    function automatic logic [WIDTH-1:0] ca_step(input logic [WIDTH-1:0] c);
        logic [WIDTH+1:0] p;
        logic [WIDTH-1:0] n;
        p = {1'b0, c, 1'b0};
        for (int i = 0; i < WIDTH; i++) begin
            n[i] = p[i+2] ^ p[i] ^ (RULE_MASK[i] & c[i]);
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] ca_advance(input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] s;
        s = c;
`ifdef CA_PRNG_LEAP_EN
        for (int k = 0; k < LEAP; k++) begin
            s = ca_step(s);
        end
`else
        s = ca_step(s);
`endif
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= S_IDLE;
            state_q <= SEED;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        adv     = ca_advance(state_q);
        // Saturating increment; only reachable when the limit is disabled.
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + COUNT_W'(1);

        if (load) begin
            // A zero seed would lock the CA at zero forever, so substitute SEED.
            state_d = (load_seed == '0) ? SEED : load_seed;
            err_d   = err_q | (load_seed == '0);
            cnt_d   = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            fsm_d   = S_IDLE;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    valid_d = 1'b0;
                    if (enable) begin
                        fsm_d   = S_RUN;
                        data_d  = state_q;
                        state_d = adv;
                        valid_d = 1'b1;
                    end
                end
                S_RUN: begin
                    // Without a handshake everything holds, enable included.
                    if (valid_q && out_ready) begin
                        cnt_d = cnt_inc;
                        if ((MAX_COUNT != 0) && (cnt_inc == MAX_CNT)) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            fsm_d   = S_DONE;
                        end else if (enable) begin
                            data_d  = state_q;
                            state_d = adv;
                            valid_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            fsm_d   = S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    fsm_d   = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign done       = done_q;
    assign seed_err   = err_q;
    assign sample_cnt = cnt_q;

endmodule

// File: doc/ca_prng_gen.md
Name: ca_prng_gen

Overview:
Parametrised hybrid rule-90/150 cellular-automaton pseudo-random generator with null boundaries. It is the successor to the fixed 24-bit, two-phase CA generator.
- Advances one CA step per accepted sample instead of every other clock.
- Supports runtime reseed, a valid/ready output handshake and a programmable sample limit.
- Feeds BIST/test-pattern and scrambler consumers in the same fabric.

Parameters:
WIDTH, 24, number of CA cells (>=3).
RULE_MASK, 24'hD55555, bit i=1 -> cell i uses rule 150 (self term included); bit i=0 -> rule 90.
SEED, 24'h99B3AB, state loaded at reset and substituted for an all-zero load.
MAX_COUNT, 1048576, samples emitted before DONE; 0 = unlimited.
COUNT_W, 21, sample counter width; must hold MAX_COUNT.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
enable  in  1  allows sample generation
load  in  1  one-cycle seed load strobe
load_seed  in  WIDTH  seed value, sampled when load=1
out_data  out  WIDTH  current sample
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts sample
done  out  1  MAX_COUNT samples accepted
seed_err  out  1  sticky: an all-zero seed was loaded
sample_cnt  out  COUNT_W  samples accepted since reset/load

Behaviour:
- CA step next(c): next[i] = c[i+1] ^ c[i-1] ^ (RULE_MASK[i] & c[i]); c[-1] = c[WIDTH] = 0. The step is purely combinational.
- Reset (rst_n=0 at clk edge):
  - state = SEED, out_data = 0, out_valid = 0, done = 0, seed_err = 0, sample_cnt = 0, FSM = IDLE.
- FSM states IDLE, RUN, DONE:
  - IDLE: out_valid=0. If enable=1, move to RUN. On the same edge, out_data <= state, state <= next(state), out_valid <= 1.
  - RUN, on handshake (out_valid & out_ready):
    - sample_cnt increments.
    - If the new count equals MAX_COUNT (MAX_COUNT != 0): out_valid <= 0, done <= 1, move to DONE.
    - Else if enable=1: out_data <= state, state <= next(state), out_valid stays 1. This gives back-to-back samples at one per clock.
    - Else: out_valid <= 0 and move to IDLE.
  - RUN with out_valid=1 and out_ready=0: out_data and state are held stable; enable is ignored until the handshake.
  - DONE: out_valid=0, done=1. Stays in DONE until load or reset.
- Load (load=1):
  - Highest priority after reset; takes effect from any state, including mid-handshake (a pending sample is discarded).
  - state <= load_seed, or SEED if load_seed==0, in which case seed_err <= 1.
  - sample_cnt <= 0, out_valid <= 0, done <= 0, FSM <= IDLE. enable is ignored on the load cycle.
- Latency: first out_valid is 1 clock after the enable edge in IDLE. First sample equals the seed.
- sample_cnt saturates at its maximum when MAX_COUNT=0 (unlimited); generation continues.
- State never reaches zero: the CA with a nonzero seed and a valid rule mask is non-singular.

Optional Feature:
CA_PRNG_LEAP_EN:
- Defined: adds parameter LEAP (default 1, range 1..8). Each state advance applies next() LEAP times, unrolled combinationally. Emitted samples are LEAP steps apart; first sample is still the seed.
- Undefined: the LEAP parameter is absent and one step is applied per sample.

Test Plan:
1. Default params, reset then enable=1, out_ready=1 -> first out_data=24'h99B3AB one clock later; out_valid stays 1 every cycle; sample_cnt increments each clock.
2. WIDTH=4, RULE_MASK=4'hD, SEED=4'h1, enable=1, out_ready=1 -> out_data sequence 4'h1, 4'h3, 4'h6, ...
3. Backpressure: hold out_ready=0 for 5 cycles mid-stream -> out_data, sample_cnt frozen; on release, the next sample is exactly the successor with no skip or duplicate.
4. MAX_COUNT=3, out_ready=1 -> exactly 3 handshakes, then out_valid=0, done=1, sample_cnt=3. Remains so with enable=1 until load.
5. load=1 with load_seed=0 while out_valid=1 -> out_valid=0 next clock, seed_err=1, done=0, sample_cnt=0; next sample after enable = SEED.
6. Synchronous reset asserted mid-stream with enable=1 -> all outputs at reset values the following clock; seed_err cleared; sequence restarts from SEED.
